cic_interp_multich: RTL

//  Parametrised multi-channel CIC interpolator: N comb stages, zero-stuff by R=2^k, N integrators.

---
 rtl/cic_interp_multich.sv | 127 ++++++++++++
 1 files changed

// File: rtl/cic_interp_multich.sv
// Multi-channel CIC interpolator: N combs at the frame rate, zero-stuff by 2^k,
// N cascaded integrators at clk rate, rounded and saturated normalisation.
module cic_interp_multich #(
   parameter int DW        = 16,
   parameter int CH        = 2,
   parameter int N         = 3,
   parameter int LOG2_RMAX = 7,
   parameter int KW        = $clog2(LOG2_RMAX + 1),
   parameter int W         = DW + N * LOG2_RMAX
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [KW-1:0]    ratio_log2,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [CH*DW-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CH*DW-1:0] out_data,
   output logic [CH-1:0]    out_sat
);

   localparam int PW = (LOG2_RMAX > 0) ? LOG2_RMAX : 1;
   localparam logic [PW:0] ONEP = 1;
   localparam logic signed [W:0] ONEW = 1;
   localparam logic signed [W:0] PMAX = (W+1)'(2**(DW-1) - 1);
   localparam logic signed [W:0] NMIN = (W+1)'(-(2**(DW-1)));

   typedef enum logic {IDLE, RUN} st_t;

   st_t             state;
   logic [PW-1:0]   phase;
   logic [KW-1:0]   k_l;
   logic signed [W-1:0] cd [CH][N];
   logic signed [W-1:0] cv [CH];
   logic signed [W-1:0] ig [CH][N];

   logic signed [W-1:0] cx [CH][N+1];
   logic signed [W-1:0] ix [CH][N+1];
   logic signed [W:0]   av;
   logic [CH*DW-1:0]    nd;
   logic [CH-1:0]       ns;
   int                  sh;
   logic                step, last, acc;

   assign step     = (state == RUN) & (!out_valid | out_ready);
   assign last     = ({1'b0, phase} == ((ONEP << k_l) - ONEP));
   assign in_ready = !rst & ((state == IDLE) | (step & last));
   assign acc      = in_valid & in_ready;

   // comb chain on the incoming frame, integrator cascade on the held comb value
   always_comb begin
      for (int c = 0; c < CH; c++) begin
         cx[c][0] = {{(W-DW){in_data[c*DW+DW-1]}}, in_data[c*DW +: DW]};
         for (int i = 0; i < N; i++)
            cx[c][i+1] = cx[c][i] - cd[c][i];
         ix[c][0] = (phase == '0) ? cv[c] : '0;
         for (int i = 0; i < N; i++)
            ix[c][i+1] = ig[c][i] + ix[c][i];
      end
   end

   always_comb begin
      nd = '0;
      ns = '0;
      av = '0;
      sh = (N - 1) * int'(k_l);
      for (int c = 0; c < CH; c++) begin
         av = {ix[c][N][W-1], ix[c][N]};
         if (sh > 0)
            av = (av + (ONEW << (sh - 1))) >>> sh;
         if (av > PMAX) begin
            nd[c*DW +: DW] = PMAX[DW-1:0];
            ns[c] = 1'b1;
         end else if (av < NMIN) begin
            nd[c*DW +: DW] = NMIN[DW-1:0];
            ns[c] = 1'b1;
         end else begin
            nd[c*DW +: DW] = av[DW-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         phase     <= '0;
         k_l       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= '0;
         for (int c = 0; c < CH; c++) begin
            cv[c] <= '0;
            for (int i = 0; i < N; i++) begin
               cd[c][i] <= '0;
               ig[c][i] <= '0;
            end
         end
      end else begin
         if (step) begin
            for (int c = 0; c < CH; c++)
               for (int i = 0; i < N; i++)
                  ig[c][i] <= ix[c][i+1];
            out_data  <= nd;
            out_sat   <= ns;
            out_valid <= 1'b1;
            phase     <= phase + PW'(1);
            if (last)
               state <= IDLE;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         // a new frame overrides the end-of-frame return to IDLE
         if (acc) begin
            for (int c = 0; c < CH; c++) begin
               cv[c] <= cx[c][N];
               for (int i = 0; i < N; i++)
                  cd[c][i] <= cx[c][i];
            end
            k_l   <= ratio_log2;
            phase <= '0;
            state <= RUN;
         end
      end
   end

endmodule
